// File: rtl/hot_addr_tracker.sv
// Purpose : direct-mapped frequency table of sampled addresses; an epoch rising
//           edge scans the table in index order and reports entries whose count
//           reaches HOT_THRESHOLD, clearing the table as the scan passes.
// Latency : a sample updates its entry on the next edge; the scan starts on the
//           edge after the epoch rise and takes NUM_ENTRIES cycles plus one per
//           reported entry (plus any stall cycles).
// Backpressure: hot_addr/hot_addr_valid hold until hot_addr_ready; the scan
//           stalls meanwhile. Samples and epoch edges arriving while busy are
//           dropped.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   input_addr(_valid) sampled address and its single-cycle strobe
//   epoch              level signal; its rising edge starts a report scan
//   hot_addr(_valid)   reported hot address, valid held until accepted
//   hot_addr_ready     consumer acceptance
//   busy               high while scanning or emitting
//   drop_cnt           (only with HOT_TRACKER_DROP_CNT_EN) saturating count of
//                      samples dropped while busy
//
// Optional feature macro: HOT_TRACKER_DROP_CNT_EN
module hot_addr_tracker #(
  parameter int ADDR_SIZE     = 21,
  parameter int NUM_ENTRIES   = 16,
  parameter int CNT_WIDTH     = 8,
  parameter int HOT_THRESHOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE-1:0] input_addr,
  input  logic                 input_addr_valid,
  input  logic                 epoch,
  output logic [ADDR_SIZE-1:0] hot_addr,
  output logic                 hot_addr_valid,
  input  logic                 hot_addr_ready,
  output logic                 busy
`ifdef HOT_TRACKER_DROP_CNT_EN
  ,
  output logic [15:0]          drop_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_EMIT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_vld [NUM_ENTRIES];
  logic [ADDR_SIZE-1:0] r_tag [NUM_ENTRIES];
  logic [CNT_WIDTH-1:0] r_cnt [NUM_ENTRIES];

  logic [IDX_W-1:0]     r_idx;
  logic                 r_epoch_d;
  logic [ADDR_SIZE-1:0] r_hot_addr;
  logic                 r_hot_vld;

  logic                 w_epoch_rise;
  logic                 w_upd;
  logic [IDX_W-1:0]     w_in_idx;
  logic [ADDR_SIZE-1:0] w_new_tag;
  logic [CNT_WIDTH-1:0] w_new_cnt;
  logic                 w_hot;
  logic                 w_last;
  logic                 w_clr;
  logic                 w_load;

  assign w_epoch_rise = epoch & ~r_epoch_d;
  assign w_upd        = (r_state == ST_IDLE) && input_addr_valid;
  assign w_in_idx     = input_addr[IDX_W-1:0];
  assign w_last       = (r_idx == IDX_W'(NUM_ENTRIES - 1));
  assign w_hot        = r_vld[r_idx] && (r_cnt[r_idx] >= CNT_WIDTH'(HOT_THRESHOLD));

  assign hot_addr       = r_hot_addr;
  assign hot_addr_valid = r_hot_vld;
  assign busy           = (r_state != ST_IDLE);

  // Replacement policy: a resident tag is evicted only after misses have worn
  // its count down to 1, so a frequent address survives occasional aliases.
  always_comb begin
    w_new_tag = r_tag[w_in_idx];
    w_new_cnt = r_cnt[w_in_idx];
    if (!r_vld[w_in_idx]) begin
      w_new_tag = input_addr;
      w_new_cnt = CNT_WIDTH'(1);
    end else if (r_tag[w_in_idx] == input_addr) begin
      if (r_cnt[w_in_idx] != {CNT_WIDTH{1'b1}}) begin
        w_new_cnt = r_cnt[w_in_idx] + CNT_WIDTH'(1);
      end
    end else if (r_cnt[w_in_idx] <= CNT_WIDTH'(1)) begin
      w_new_tag = input_addr;
      w_new_cnt = CNT_WIDTH'(1);
    end else begin
      w_new_cnt = r_cnt[w_in_idx] - CNT_WIDTH'(1);
    end
  end

  // Next state. w_clr retires the entry at r_idx and advances the index;
  // w_load captures the entry's tag for reporting.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_epoch_rise) begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_hot) begin
          w_load      = 1'b1;
          w_state_nxt = ST_EMIT;
        end else begin
          w_clr = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_EMIT: begin
        if (hot_addr_ready) begin
          w_clr       = 1'b1;
          w_state_nxt = w_last ? ST_IDLE : ST_SCAN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_epoch_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_epoch_d <= epoch;
    end
  end

  // Index wraps naturally from NUM_ENTRIES-1 to 0 (power-of-two depth), so it
  // is already 0 when the next scan begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (r_state == ST_IDLE) begin
      r_idx <= '0;
    end else if (w_clr) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hot_addr <= '0;
      r_hot_vld  <= 1'b0;
    end else if (w_load) begin
      r_hot_addr <= r_tag[r_idx];
      r_hot_vld  <= 1'b1;
    end else if ((r_state == ST_EMIT) && hot_addr_ready) begin
      r_hot_vld  <= 1'b0;
    end
  end

  // Sample updates happen only in IDLE and clears only while busy, so the two
  // write sources never collide on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_vld[i] <= 1'b0;
        r_tag[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_upd && (w_in_idx == IDX_W'(i))) begin
          r_vld[i] <= 1'b1;
          r_tag[i] <= w_new_tag;
          r_cnt[i] <= w_new_cnt;
        end else if (w_clr && (r_idx == IDX_W'(i))) begin
          r_vld[i] <= 1'b0;
          r_cnt[i] <= '0;
        end
      end
    end
  end

`ifdef HOT_TRACKER_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (input_addr_valid && (r_state != ST_IDLE) && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: doc/hot_addr_tracker.md
HOT_ADDR_TRACKER -- requirements
Module: hot_addr_tracker

Interface
REQ-001 Parameter ADDR_SIZE, default 21, sampled address width.
REQ-002 Parameter NUM_ENTRIES, default 16, table depth, power of two >= 2; IDX_W = log2(NUM_ENTRIES).
REQ-003 Parameter CNT_WIDTH, default 8, per-entry counter width.
REQ-004 Parameter HOT_THRESHOLD, default 4, minimum count for an entry to be reported hot.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 input_addr  input  ADDR_SIZE  sampled address from the sampling stage.
REQ-008 input_addr_valid  input  1  single-cycle strobe qualifying input_addr.
REQ-009 epoch  input  1  level epoch signal; its rising edge triggers a report scan.
REQ-010 hot_addr  output  ADDR_SIZE  reported hot address.
REQ-011 hot_addr_valid  output  1  hot_addr is valid; held until accepted.
REQ-012 hot_addr_ready  input  1  consumer accepts hot_addr when high with hot_addr_valid.
REQ-013 busy  output  1  high while state is SCAN or EMIT.

Function
REQ-014 Table SHALL hold NUM_ENTRIES entries {vld, tag[ADDR_SIZE], cnt[CNT_WIDTH]}, direct-mapped by idx = input_addr[IDX_W-1:0].
REQ-015 States SHALL be IDLE, SCAN, EMIT; reset state IDLE.
REQ-016 In IDLE, a valid sample SHALL update its entry at the next clock edge: invalid entry -> vld=1, tag=addr, cnt=1; hit (tag==addr) -> cnt+1, saturating at 2^CNT_WIDTH-1; miss with cnt<=1 -> tag=addr, cnt=1; miss with cnt>1 -> cnt-1.
REQ-017 Epoch rising edge SHALL be detected with a registered copy of epoch (reset 0); epoch held high SHALL trigger only one scan.
REQ-018 Epoch edge in IDLE SHALL move to SCAN with scan index 0; a sample valid in the same cycle SHALL still be applied and be visible to the scan.
REQ-019 In SCAN, per cycle at scan index i: if vld && cnt>=HOT_THRESHOLD, load hot_addr=tag, assert hot_addr_valid, go to EMIT; otherwise clear vld of entry i and advance i.
REQ-020 In EMIT, hot_addr and hot_addr_valid SHALL remain stable until hot_addr_ready is high; on that handshake, deassert hot_addr_valid next cycle, clear entry i, advance i, return to SCAN.
REQ-021 Advancing past index NUM_ENTRIES-1 SHALL return to IDLE, with the table fully cleared; busy falls the same edge.
REQ-022 Samples arriving while busy SHALL be dropped without modifying the table.
REQ-023 Epoch edges while busy SHALL be ignored (not queued).
REQ-024 Report order SHALL be ascending table index; at most one hot_addr per entry per epoch.
REQ-025 Scan with no hot entries SHALL take exactly NUM_ENTRIES cycles in SCAN.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, scan index 0, all vld 0, all cnt 0, hot_addr 0, hot_addr_valid 0, busy 0, epoch history 0.
REQ-027 Reset asserted mid-SCAN or mid-EMIT SHALL abort the scan; no hot_addr_valid after reset release until a new epoch edge.

Configuration
REQ-028 Macro HOT_TRACKER_DROP_CNT_EN defined: add output drop_cnt (16 bits) counting samples dropped per REQ-022, saturating at 0xFFFF, reset 0, not cleared by epoch.
REQ-029 Macro HOT_TRACKER_DROP_CNT_EN undefined: drop_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 Four samples 0x00013, epoch pulse, ready held high -> exactly one hot_addr=0x00013 handshake; busy high 17 cycles; table empty afterwards.
REQ-031 Three samples 0x00005, epoch pulse -> no hot_addr_valid; busy high exactly 16 cycles.
REQ-032 Samples 0x00003 x3 then 0x00013 x3 (same idx 3) -> entry ends tag=0x00013, cnt=1; epoch reports nothing.
REQ-033 Hot entries at idx 2 and 9, hot_addr_ready low 10 cycles at first EMIT -> hot_addr/valid stable for all 10 cycles; idx 2 reported before idx 9; with macro, 5 samples during scan -> drop_cnt=5.
REQ-034 300 samples of 0x00001 with CNT_WIDTH=8 -> cnt saturates at 255, never wraps; epoch reports 0x00001 once.
REQ-035 rst_n pulsed low during EMIT -> hot_addr_valid, busy, hot_addr 0 immediately; no output until next epoch edge.
